// File: rtl/audio_codec_pkg.sv
// Shared types and constants for the audio codec data path.
package audio_codec_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } i2s_state_e;

  localparam int FRAME_BITS  = 64;
  localparam int SLOT_BITS   = 32;
  localparam int DEF_CLK_DIV = 8;
endpackage

// File: rtl/audio_bclk_gen.sv
// BCLK divider: toggles BCLK every CLK_DIV cycles while running and reports
// fall/rise events; a suppressed fall keeps BCLK high so the frame can end cleanly.
module audio_bclk_gen
  import audio_codec_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic CLK_50,
  input  logic RESET_n,
  input  logic i_run,
  input  logic i_suppress,
  output logic o_bclk,
  output logic o_fall,
  output logic o_rise,
  output logic o_fall_sup
);
  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] r_div_cnt;
  logic          r_bclk;
  logic          w_tc;

  assign w_tc       = i_run && (r_div_cnt == DW'(CLK_DIV - 1));
  assign o_fall     = w_tc && r_bclk && !i_suppress;
  assign o_fall_sup = w_tc && r_bclk && i_suppress;
  assign o_rise     = w_tc && !r_bclk;
  assign o_bclk     = r_bclk;

  always_ff @(posedge CLK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b1;
    end else if (!i_run) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b1;
    end else begin
      r_div_cnt <= w_tc ? '0 : r_div_cnt + 1'b1;
      if (o_fall || o_rise) r_bclk <= ~r_bclk;
    end
  end
endmodule

// File: rtl/audio_i2s_master.sv
// Stereo I2S master: 64-BCLK frames, MSB one BCLK after each LRCK edge.
// DAC words shift out on BCLK falls, ADC bits are captured on BCLK rises.
module audio_i2s_master
  import audio_codec_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int SAMPLE_W = 16
) (
  input  logic                CLK_50,
  input  logic                RESET_n,
  input  logic                iENABLE,
  output logic                oBCLK,
  output logic                oLRCK,
  output logic                oDACDAT,
  input  logic                iADCDAT,
  input  logic [SAMPLE_W-1:0] iDAC_L,
  input  logic [SAMPLE_W-1:0] iDAC_R,
  output logic                oDAC_RD,
  output logic [SAMPLE_W-1:0] oADC_L,
  output logic [SAMPLE_W-1:0] oADC_R,
  output logic                oADC_VALID,
  output logic                oBUSY
);
  localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS - 1);
  localparam logic [5:0] BIT_CAP  = 6'(SLOT_BITS + SAMPLE_W);

  i2s_state_e r_state, w_state_nxt;
  logic w_run, w_suppress, w_fall, w_rise, w_fall_sup;

  logic [5:0]          r_bit_cnt, w_bit_nxt;
  logic [4:0]          w_k_nxt;
  logic                w_k_nxt_dat, w_k_dat;
  logic                r_lrck, r_dacdat, r_dac_rd, r_cap, r_adc_valid, r_busy;
  logic [SAMPLE_W-1:0] r_dac_sh_l, r_dac_sh_r;
  logic [SAMPLE_W-1:0] r_adc_sh_l, r_adc_sh_r, r_adc_l, r_adc_r;
  logic [SAMPLE_W:0]   w_adc_l_ext, w_adc_r_ext;

  audio_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .CLK_50     (CLK_50),
    .RESET_n    (RESET_n),
    .i_run      (w_run),
    .i_suppress (w_suppress),
    .o_bclk     (oBCLK),
    .o_fall     (w_fall),
    .o_rise     (w_rise),
    .o_fall_sup (w_fall_sup)
  );

  always_ff @(posedge CLK_50 or negedge RESET_n) begin
    if (!RESET_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (iENABLE) w_state_nxt = S_RUN;
      S_RUN:   if (!iENABLE) w_state_nxt = S_DRAIN;
      S_DRAIN: if (iENABLE) w_state_nxt = S_RUN;
               else if (w_fall_sup) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The wrap fall is only suppressed when the drain is really ending this cycle.
  always_comb begin
    w_run      = (r_state != S_IDLE);
    w_suppress = (r_state == S_DRAIN) && !iENABLE && (r_bit_cnt == BIT_LAST);
  end

  assign w_bit_nxt   = r_bit_cnt + 6'd1;
  assign w_k_nxt     = w_bit_nxt[4:0];
  assign w_k_nxt_dat = (w_k_nxt != 5'd0) && (int'(w_k_nxt) <= SAMPLE_W);
  assign w_k_dat     = (r_bit_cnt[4:0] != 5'd0) && (int'(r_bit_cnt[4:0]) <= SAMPLE_W);
  assign w_adc_l_ext = {r_adc_sh_l, iADCDAT};
  assign w_adc_r_ext = {r_adc_sh_r, iADCDAT};

  always_ff @(posedge CLK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      r_bit_cnt  <= BIT_LAST;
      r_lrck     <= 1'b1;
      r_dacdat   <= 1'b0;
      r_dac_rd   <= 1'b0;
      r_dac_sh_l <= '0;
      r_dac_sh_r <= '0;
    end else begin
      r_dac_rd <= 1'b0;
      if (!w_run || w_fall_sup) begin
        r_bit_cnt <= BIT_LAST;
        r_lrck    <= 1'b1;
        r_dacdat  <= 1'b0;
      end else if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrck    <= w_bit_nxt[5];
        r_dacdat  <= 1'b0;
        if (w_bit_nxt == 6'd0) begin
          r_dac_sh_l <= iDAC_L;
          r_dac_sh_r <= iDAC_R;
          r_dac_rd   <= 1'b1;
        end else if (w_k_nxt_dat) begin
          if (w_bit_nxt[5]) begin
            r_dacdat   <= r_dac_sh_r[SAMPLE_W-1];
            r_dac_sh_r <= r_dac_sh_r << 1;
          end else begin
            r_dacdat   <= r_dac_sh_l[SAMPLE_W-1];
            r_dac_sh_l <= r_dac_sh_l << 1;
          end
        end
      end
    end
  end

  // Right LSB completes the frame: publish it, strobe valid one cycle later.
  always_ff @(posedge CLK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      r_adc_sh_l  <= '0;
      r_adc_sh_r  <= '0;
      r_adc_l     <= '0;
      r_adc_r     <= '0;
      r_cap       <= 1'b0;
      r_adc_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cap       <= 1'b0;
      r_adc_valid <= r_cap;
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_rise && w_k_dat) begin
        if (r_lrck) r_adc_sh_r <= w_adc_r_ext[SAMPLE_W-1:0];
        else        r_adc_sh_l <= w_adc_l_ext[SAMPLE_W-1:0];
        if (r_bit_cnt == BIT_CAP) begin
          r_adc_l <= r_adc_sh_l;
          r_adc_r <= w_adc_r_ext[SAMPLE_W-1:0];
          r_cap   <= 1'b1;
        end
      end
    end
  end

  assign oLRCK      = r_lrck;
  assign oDACDAT    = r_dacdat;
  assign oDAC_RD    = r_dac_rd;
  assign oADC_L     = r_adc_l;
  assign oADC_R     = r_adc_r;
  assign oADC_VALID = r_adc_valid;
  assign oBUSY      = r_busy;
endmodule

// File: tb/tb_audio_i2s_master.sv
// Scoreboard bench: an I2S codec model feeds ADC words and decodes DAC words,
// expected words are queued as they are issued and popped when the DUT delivers.
module tb_audio_i2s_master;
  localparam int CD    = 8;
  localparam int W     = 16;
  localparam int FRAME = 128 * CD;

  logic         CLK_50, RESET_n, iENABLE, iADCDAT;
  logic [W-1:0] iDAC_L, iDAC_R;
  logic         oBCLK, oLRCK, oDACDAT, oDAC_RD, oADC_VALID, oBUSY;
  logic [W-1:0] oADC_L, oADC_R;

  int total, bad, cyc;
  logic [2*W-1:0] exp_dac[$];
  logic [2*W-1:0] exp_adc[$];

  audio_i2s_master #(.CLK_DIV(CD), .SAMPLE_W(W)) dut (
    .CLK_50(CLK_50), .RESET_n(RESET_n), .iENABLE(iENABLE),
    .oBCLK(oBCLK), .oLRCK(oLRCK), .oDACDAT(oDACDAT), .iADCDAT(iADCDAT),
    .iDAC_L(iDAC_L), .iDAC_R(iDAC_R), .oDAC_RD(oDAC_RD),
    .oADC_L(oADC_L), .oADC_R(oADC_R), .oADC_VALID(oADC_VALID), .oBUSY(oBUSY)
  );

  initial CLK_50 = 1'b0;
  always #10 CLK_50 = ~CLK_50;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
    end
  endtask

  // Feeder: the words on iDAC_* at a read strobe are what must come out serially.
  initial begin
    iDAC_L = 16'hA5C3;
    iDAC_R = 16'h0F81;
    forever begin
      @(negedge CLK_50);
      if (RESET_n && oDAC_RD) begin
        exp_dac.push_back({iDAC_L, iDAC_R});
        iDAC_L = W'($urandom);
        iDAC_R = W'($urandom);
      end
    end
  end

  // Codec ADC side: j counts BCLK falls since the last LRCK edge, bit j=1 is the MSB.
  initial begin
    logic pb, cl, first;
    int j;
    logic [W-1:0] wl, wr;
    pb = 1'b1; cl = 1'b1; first = 1'b1; j = 0; wl = '0; wr = '0;
    iADCDAT = 1'b0;
    forever begin
      @(negedge CLK_50);
      if (!RESET_n) begin
        pb = 1'b1; cl = 1'b1; j = 0;
        continue;
      end
      if (pb && !oBCLK) begin
        if (oLRCK != cl) begin
          cl = oLRCK;
          j  = 0;
          if (!oLRCK) begin
            if (first) begin wl = 16'h1234; wr = 16'hFEDC; first = 1'b0; end
            else begin wl = W'($urandom); wr = W'($urandom); end
            exp_adc.push_back({wl, wr});
          end
        end else j++;
        if (j >= 1 && j <= W) iADCDAT = cl ? wr[W-j] : wl[W-j];
        else                  iADCDAT = 1'($urandom);
      end
      pb = oBCLK;
    end
  end

  // Monitor: codec DAC receiver, BCLK/frame cadence and ADC scoreboard.
  initial begin
    logic pb, pl;
    int j, lrd, ledge, rise_c;
    logic [W-1:0] rl, rr;
    logic [2*W-1:0] e;
    pb = 1'b1; pl = 1'b1; j = 0; lrd = -1; ledge = -1; rise_c = -100; rl = '0; rr = '0;
    cyc = 0;
    forever begin
      @(negedge CLK_50);
      cyc++;
      if (!RESET_n || !oBUSY) begin lrd = -1; ledge = -1; end
      if (!RESET_n) begin
        pb = 1'b1; pl = 1'b1; j = 0;
        continue;
      end
      if (oBCLK != pb) begin
        if (ledge >= 0) chk("bclk_half", cyc - ledge, CD);
        ledge = cyc;
        if (!oBCLK) begin
          if (oLRCK != pl) begin pl = oLRCK; j = 0; end
          else j++;
        end else if (j >= 1 && j <= W) begin
          if (pl) rr = {rr[W-2:0], oDACDAT};
          else    rl = {rl[W-2:0], oDACDAT};
          if (pl && j == W) begin
            rise_c = cyc;
            chk("dac_avail", exp_dac.size() > 0, 1);
            if (exp_dac.size() > 0) begin
              e = exp_dac.pop_front();
              chk("dac_l", rl, e[2*W-1:W]);
              chk("dac_r", rr, e[W-1:0]);
            end
          end
        end else chk("dac_pad_bit", oDACDAT, 0);
      end
      pb = oBCLK;
      if (oDAC_RD) begin
        if (lrd >= 0) chk("rd_period", cyc - lrd, FRAME);
        lrd = cyc;
      end
      if (oADC_VALID) begin
        chk("adc_avail", exp_adc.size() > 0, 1);
        chk("adc_align", cyc - rise_c, 1);
        if (exp_adc.size() > 0) begin
          e = exp_adc.pop_front();
          chk("adc_l", oADC_L, e[2*W-1:W]);
          chk("adc_r", oADC_R, e[W-1:0]);
        end
      end
    end
  end

  task automatic idle_chk(input string nm);
    chk(nm, {oBCLK, oLRCK, oDACDAT, oDAC_RD, oADC_VALID, oBUSY}, 6'b110000);
  endtask

  task automatic wait_rd();
    int n;
    logic seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 2 * FRAME) begin
      @(posedge CLK_50); #1;
      n++;
      seen = oDAC_RD;
    end
    chk("wait_rd", seen, 1);
  endtask

  task automatic wait_falls(input int nf);
    int n, f;
    logic pb;
    n = 0; f = 0; pb = oBCLK;
    while (f < nf && n < 4 * CD * nf) begin
      @(posedge CLK_50); #1;
      n++;
      if (pb && !oBCLK) f++;
      pb = oBCLK;
    end
    chk("wait_falls", f, nf);
  endtask

  task automatic start_latency();
    int n;
    logic seen;
    n = 0; seen = 1'b0;
    iENABLE = 1'b1;
    while (!seen && n < CD + 20) begin
      @(posedge CLK_50); #1;
      n++;
      seen = oDAC_RD;
    end
    chk("start_latency", n, CD + 1);
  endtask

  task automatic drain_to_idle(input string nm);
    int n;
    n = 0;
    while (oBUSY && n < 2 * FRAME) begin
      @(posedge CLK_50); #1;
      n++;
    end
    chk(nm, oBUSY, 0);
    chk("dac_queue_empty", exp_dac.size(), 0);
    chk("adc_queue_empty", exp_adc.size(), 0);
  endtask

  initial begin
    total = 0; bad = 0;
    RESET_n = 1'b0; iENABLE = 1'b0;
    repeat (3) @(posedge CLK_50);
    #1;
    idle_chk("reset_out");
    chk("reset_adc", {oADC_L, oADC_R}, 0);
    #1 RESET_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      @(posedge CLK_50); #1;
      idle_chk("idle_out");
    end

    // DAC shift-out and ADC capture for several frames, then drain at bit 10.
    #1 start_latency();
    repeat (3) wait_rd();
    wait_falls(10);
    #1 iENABLE = 1'b0;
    drain_to_idle("drain_idle");
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK_50); #1;
      idle_chk("post_drain_out");
    end

    // Re-enable while draining: cadence must not break.
    #1 start_latency();
    wait_falls(20);
    #1 iENABLE = 1'b0;
    repeat (50) @(posedge CLK_50);
    #2 iENABLE = 1'b1;
    repeat (2) wait_rd();

    // Asynchronous reset at bit 40 of a frame.
    wait_rd();
    wait_falls(40);
    #1 RESET_n = 1'b0;
    iENABLE = 1'b0;
    exp_dac.delete();
    exp_adc.delete();
    #1;
    idle_chk("midrst_out");
    chk("midrst_adc", {oADC_L, oADC_R}, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK_50); #1;
      chk("midrst_valid", oADC_VALID, 0);
    end
    #1 RESET_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK_50); #1;
      idle_chk("post_rst_out");
    end
    #1 start_latency();
    repeat (2) wait_rd();
    #1 iENABLE = 1'b0;
    drain_to_idle("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_i2s_master.md
# audio_i2s_master

Stereo I2S master for the audio codec's data path. It runs downstream of the SPI register-configuration controller and starts streaming once the codec is configured. The block generates BCLK and LRCK from CLK_50 and shifts DAC samples out. In parallel it captures ADC samples and presents them as parallel stereo words with a valid strobe. iENABLE is driven from the configuration controller's done/OK status.

## Interface
- CLK_DIV, 8: BCLK half-period in CLK_50 cycles; at 8, BCLK = 3.125 MHz and Fs = 48.828 kHz. Legal range is 2..255.
- SAMPLE_W, 16: audio sample width. Legal range is 1..31.
- CLK_50, input, 1: system clock.
- RESET_n, input, 1: reset, asynchronous, active-low.
- iENABLE, input, 1: run request. Driven high once codec SPI configuration is done.
- oBCLK, output, 1: codec bit clock.
- oLRCK, output, 1: word select; 0 = left slot, 1 = right slot.
- oDACDAT, output, 1: serial DAC data to codec.
- iADCDAT, input, 1: serial ADC data from codec.
- iDAC_L / iDAC_R, input, SAMPLE_W each: DAC samples, sampled at frame start.
- oDAC_RD, output, 1: 1-cycle pulse when iDAC_L/iDAC_R are latched.
- oADC_L / oADC_R, output, SAMPLE_W each: last complete ADC frame.
- oADC_VALID, output, 1: 1-cycle pulse when oADC_L/oADC_R are updated.
- oBUSY, output, 1: high in RUN and DRAIN.

## Operation
- Format: standard I2S with 32 BCLK per slot and 64 BCLK per frame.
  - The MSB is delayed one BCLK after each LRCK edge.
  - Data is driven on BCLK falling edges and sampled on BCLK rising edges.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and runs only outside IDLE.
  - At terminal count, BCLK toggles: a 1→0 toggle is a "fall" event, a 0→1 toggle is a "rise" event.
- bit_cnt (6 bits):
  - Increments at each fall event and wraps 63→0.
  - LRCK = bit_cnt[5], updated at the fall event.
  - Slot index k = bit_cnt[4:0].
- DAC path:
  - At the fall event where bit_cnt becomes 0, iDAC_L/iDAC_R are loaded into the shift registers and oDAC_RD pulses in that same cycle.
  - For k = 1..SAMPLE_W, oDACDAT carries sample bit SAMPLE_W-k (MSB first).
  - For every other k, oDACDAT = 0.
- ADC path:
  - At each rise event with k in 1..SAMPLE_W, iADCDAT is shifted into the left or right shift register, selected by LRCK.
  - At the rise event with bit_cnt = 32+SAMPLE_W (the right LSB), both shift registers are copied to oADC_L/oADC_R. oADC_VALID pulses on the next CLK_50 cycle.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN when iENABLE = 1; div_cnt clears and bit_cnt = 63.
  - RUN → DRAIN when iENABLE = 0.
  - DRAIN → RUN if iENABLE returns to 1 before the frame ends; the frame simply continues.
  - DRAIN → IDLE at the fall event that would wrap 63→0. That fall is suppressed: BCLK stays 1, no DAC load and no oDAC_RD pulse.
- In IDLE: oBCLK = 1, oLRCK = 1, oDACDAT = 0, bit_cnt = 63.

## Timing
- Reset values: oBCLK = 1, oLRCK = 1, oDACDAT = 0, oADC_L = 0, oADC_R = 0, oADC_VALID = 0, oDAC_RD = 0, oBUSY = 0, state = IDLE.
- Reset asserted mid-frame forces all of the above immediately (asynchronous). No partial ADC word is published.
- Start latency: iENABLE rising is registered one cycle. The first fall event occurs CLK_DIV cycles later and produces the first oDAC_RD.
- Frame period: 128·CLK_DIV CLK_50 cycles. oDAC_RD and oADC_VALID each pulse exactly once per frame.
- ADC-to-DAC loopback latency (iADCDAT bit to the same value appearing on oDACDAT): 1 frame plus slot offset. This is fixed by the format; no extra buffering.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package audio_codec_pkg holds:
  - FSM state enum (IDLE/RUN/DRAIN)
  - FRAME_BITS = 64, SLOT_BITS = 32
  - default CLK_DIV
- Sub-module audio_bclk_gen:
  - Contains the divider and BCLK register.
  - Outputs are one-cycle fall/rise event strobes, and it takes a run/suppress input.
- The shift/capture logic and FSM stay in the top module.

## Test plan
- Reset and idle:
  - Stimulus: hold iENABLE = 0 for 1000 cycles.
  - Response: oBCLK = 1, oLRCK = 1, oDACDAT = 0, no strobes.
- DAC shift-out:
  - Stimulus: iDAC_L = 16'hA5C3, iDAC_R = 16'h0F81, CLK_DIV = 8.
  - Response: the DAC bits appear MSB-first at slot bits 1..16, left then right. BCLK period is 16 cycles, frame is 1024 cycles, and oDAC_RD pulses every 1024 cycles.
- ADC capture:
  - Stimulus: the bench codec model drives left 16'h1234 and right 16'hFEDC.
  - Response: oADC_L = 16'h1234 and oADC_R = 16'hFEDC with one oADC_VALID pulse per frame, aligned to one cycle after the right-LSB rise event.
- Drain:
  - Stimulus: drop iENABLE at bit_cnt = 10.
  - Response: the frame completes, the final oADC_VALID fires, then IDLE with BCLK = 1 and no further oDAC_RD.
- Mid-frame reset:
  - Stimulus: pulse RESET_n low at bit_cnt = 40.
  - Response: all outputs return to reset values within the same cycle, and oADC_VALID is not asserted.
  - After re-enable, the first oDAC_RD occurs CLK_DIV+1 cycles later.
- Re-enable during DRAIN:
  - Stimulus: iENABLE goes 1→0→1 within one frame.
  - Response: there is no gap in BCLK, and frame cadence is unchanged.
